ifu_fetch: RTL and testbench

- Instruction-fetch stage that drives the 2048x32 instruction BSRAM (synchronous read, 1-cycle latency) and delivers {pc, instr} to decode over a valid/ready handshake.
- Holds the fetch PC and tracks the one in-flight read. On stall it freezes the RAM via CE, so the RAM output register acts as the hold buffer.
- Accepts branch/jump redirects from execute with a 1-cycle bubble.

---
 rtl/ifu_fetch_pkg.sv | 9 +
 rtl/ifu_fetch.sv | 77 +++++++
 tb/tb_ifu_fetch.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared core constants for the instruction-fetch front end.
package ifu_fetch_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned IMEM_AW       = 11;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifu_fetch.sv
// Fetch stage: drives the synchronous instruction BSRAM and presents {pc, instr}
// to decode; the RAM output register doubles as the stall hold buffer.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ifu_fetch_pkg::RESET_PC,
  parameter int unsigned IMEM_AW  = ifu_fetch_pkg::IMEM_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_ce,
  output logic               imem_oce,
  output logic [IMEM_AW-1:0] imem_ad,
  input  logic [31:0]        imem_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_instr
);

  logic [XLEN-1:0] pc_f1_q, pc_f1_d;
  logic [XLEN-1:0] pc_f2_q, pc_f2_d;
  logic            valid_f2_q, valid_f2_d;
  logic [XLEN-1:0] redir_aligned;
  logic            adv;
  logic            ce_raw;

  assign redir_aligned = redirect_pc & ~32'h0000_0003;
  assign adv           = !valid_f2_q || out_ready;

  always_comb begin
    pc_f1_d    = pc_f1_q;
    pc_f2_d    = pc_f2_q;
    valid_f2_d = valid_f2_q;
    ce_raw     = 1'b0;
    imem_ad    = pc_f1_q[IMEM_AW+1:2];
    if (redirect_valid) begin
      // Redirect wins over stall and fetch_en; the held word is discarded.
      ce_raw     = 1'b1;
      imem_ad    = redir_aligned[IMEM_AW+1:2];
      pc_f2_d    = redir_aligned;
      pc_f1_d    = redir_aligned + 32'd4;
      valid_f2_d = 1'b1;
    end else if (adv) begin
      if (fetch_en) begin
        ce_raw     = 1'b1;
        pc_f2_d    = pc_f1_q;
        pc_f1_d    = pc_f1_q + 32'd4;
        valid_f2_d = 1'b1;
      end else begin
        valid_f2_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f1_q    <= RESET_PC;
      pc_f2_q    <= RESET_PC;
      valid_f2_q <= 1'b0;
    end else begin
      pc_f1_q    <= pc_f1_d;
      pc_f2_q    <= pc_f2_d;
      valid_f2_q <= valid_f2_d;
    end
  end

  assign imem_ce   = ce_raw && !reset;
  assign imem_oce  = 1'b1;
  assign out_valid = valid_f2_q && !redirect_valid;
  assign out_pc    = pc_f2_q;
  assign out_instr = imem_dout;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a behavioural 1-cycle-latency BSRAM model.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_ce;
  logic        imem_oce;
  logic [10:0] imem_ad;
  logic [31:0] imem_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(32'h0000_0000), .IMEM_AW(11)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_ce(imem_ce), .imem_oce(imem_oce), .imem_ad(imem_ad),
    .imem_dout(imem_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  // RAM model: word[i] = A500_0000 | i, output register cleared by reset.
  always @(posedge clk) begin
    if (reset) imem_dout <= 32'h0;
    else if (imem_ce) imem_dout <= 32'hA500_0000 | {21'h0, imem_ad};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, ".valid"}, {31'h0, out_valid}, 32'd1);
    chk({tag, ".pc"}, out_pc, pc);
    chk({tag, ".instr"}, out_instr, instr);
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; out_ready = 1'b1;
    tick(); tick(); settle();
    chk("rst.valid", {31'h0, out_valid}, 32'd0);
    chk("rst.ce", {31'h0, imem_ce}, 32'd0);
    chk("rst.pc", out_pc, 32'h0);
    chk("rst.oce", {31'h0, imem_oce}, 32'd1);

    // Streaming
    tick(); reset = 1'b0; settle();
    chk("s.issue_valid", {31'h0, out_valid}, 32'd0);
    chk("s.issue_ce", {31'h0, imem_ce}, 32'd1);
    chk("s.issue_ad", {21'h0, imem_ad}, 32'd0);
    for (int unsigned k = 0; k < 4; k++) begin
      tick(); settle();
      chk_out("stream", 4 * k, 32'hA500_0000 | k);
    end

    // Stall while 0x10 is presented
    tick(); out_ready = 1'b0; settle();
    for (int unsigned k = 0; k < 3; k++) begin
      chk_out("stall", 32'h10, 32'hA500_0004);
      chk("stall.ce", {31'h0, imem_ce}, 32'd0);
      if (k < 2) begin tick(); settle(); end
    end
    tick(); out_ready = 1'b1; settle();
    chk_out("stall.release", 32'h10, 32'hA500_0004);
    for (int unsigned k = 5; k < 9; k++) begin
      tick(); settle();
      chk_out("resume", 4 * k, 32'hA500_0000 | k);
    end

    // Stall at 0x20, then redirect to 0x103
    out_ready = 1'b0;
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; settle();
    chk("redir.valid", {31'h0, out_valid}, 32'd0);
    chk("redir.ce", {31'h0, imem_ce}, 32'd1);
    chk("redir.ad", {21'h0, imem_ad}, 32'h40);
    tick(); redirect_valid = 1'b0; out_ready = 1'b1; settle();
    chk_out("redir.target", 32'h100, 32'hA500_0040);
    tick(); settle();
    chk_out("redir.next", 32'h104, 32'hA500_0041);

    // Back-to-back redirects
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h40; settle();
    chk("b2b.v0", {31'h0, out_valid}, 32'd0);
    chk("b2b.ad0", {21'h0, imem_ad}, 32'h10);
    tick(); redirect_pc = 32'h80; settle();
    chk("b2b.v1", {31'h0, out_valid}, 32'd0);
    chk("b2b.ad1", {21'h0, imem_ad}, 32'h20);
    tick(); redirect_valid = 1'b0; settle();
    chk_out("b2b.target", 32'h80, 32'hA500_0020);

    // Alias beyond 8 KB
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_2004; settle();
    chk("alias.ad", {21'h0, imem_ad}, 32'd1);
    tick(); redirect_valid = 1'b0; settle();
    chk_out("alias.target", 32'h2004, 32'hA500_0001);

    // fetch_en drop at 0x08
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0; settle();
    tick(); redirect_valid = 1'b0; settle();
    chk_out("fe.pc0", 32'h0, 32'hA500_0000);
    tick(); settle();
    chk_out("fe.pc4", 32'h4, 32'hA500_0001);
    tick(); fetch_en = 1'b0; settle();
    chk_out("fe.pc8", 32'h8, 32'hA500_0002);
    chk("fe.ce_last", {31'h0, imem_ce}, 32'd0);
    for (int unsigned k = 0; k < 3; k++) begin
      tick(); settle();
      chk("fe.idle_valid", {31'h0, out_valid}, 32'd0);
      chk("fe.idle_ce", {31'h0, imem_ce}, 32'd0);
    end
    tick(); fetch_en = 1'b1; settle();
    chk("fe.rise_ce", {31'h0, imem_ce}, 32'd1);
    chk("fe.rise_ad", {21'h0, imem_ad}, 32'd3);
    tick(); settle();
    chk_out("fe.resume", 32'hC, 32'hA500_0003);

    // Reset mid-stream, with a redirect pending in the same cycle
    tick(); reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; settle();
    chk("mrst.ce", {31'h0, imem_ce}, 32'd0);
    tick(); redirect_valid = 1'b0; settle();
    chk("mrst.valid", {31'h0, out_valid}, 32'd0);
    chk("mrst.pc", out_pc, 32'h0);
    tick(); reset = 1'b0; settle();
    chk("mrst.issue_valid", {31'h0, out_valid}, 32'd0);
    chk("mrst.issue_ad", {21'h0, imem_ad}, 32'd0);
    tick(); settle();
    chk_out("mrst.first", 32'h0, 32'hA500_0000);
    tick(); settle();
    chk_out("mrst.second", 32'h4, 32'hA500_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
